// File: rtl/req_arbiter_8_pkg.sv
// Shared types and sizing for the 8-way request arbiter.
// Pure declarations: no latency and no flow control apply here.
// The hold counter width is derived here so every user sizes it the same way.
package arb_pkg;
    localparam int NUM_REQ = 8;
    localparam int ID_W    = 3;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    // Minimum one bit so a disabled timeout still yields a legal vector.
    function automatic int cnt_width(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction
endpackage

// File: rtl/req_arbiter_8_if.sv
// Request/grant bundle between the requesters and the arbiter.
// Wires only, so it adds no latency.
// No backpressure: requests are level-held until granted.
interface req_arbiter_8_if;
    logic [arb_pkg::NUM_REQ-1:0] req;
    logic [arb_pkg::NUM_REQ-1:0] grant;
    logic [arb_pkg::ID_W-1:0]    grant_id;
    logic                        grant_valid;
    logic                        timeout_pulse;

    modport master (output req, input grant, grant_id, grant_valid, timeout_pulse);
    modport slave  (input req, output grant, grant_id, grant_valid, timeout_pulse);
endinterface

// File: rtl/req_arbiter_8_pri_enc.sv
// Highest-set-bit encoder for the arbiter's selection vector.
// Purely combinational, zero latency.
// No backpressure; any flags a non-empty vector.
module arb_pri_enc
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] vec,
    output logic [ID_W-1:0]    id,
    output logic               any
);
    always_comb begin
        id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (vec[i]) id = ID_W'(i);
        end
    end

    assign any = |vec;
endmodule

// File: rtl/req_arbiter_8.sv
// 8-way arbiter, highest index first (rotating when ARB_ROUND_ROBIN_EN is defined).
// Grant is registered one cycle after an eligible request is sampled in IDLE.
// Holds the owner until it drops req or MAX_HOLD expires; others simply wait.
module req_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input logic            clk,
    input logic            rst_n,
    req_arbiter_8_if.slave bus
);
    localparam int            CW        = cnt_width(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);

    arb_state_t          state;
    logic [NUM_REQ-1:0]  grant_q;
    logic [NUM_REQ-1:0]  lockout;
    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  enc_in;
    logic [ID_W-1:0]     grant_id_q;
    logic [ID_W-1:0]     enc_id;
    logic [ID_W-1:0]     next_id;
    logic                grant_valid_q;
    logic                timeout_q;
    logic                enc_any;
    logic                timeout_hit;
    logic [CW-1:0]       hold_cnt;

    assign elig        = bus.req & ~lockout;
    assign timeout_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] last_id;

    // Rotate so the previous owner lands at bit 0 (lowest priority); 3-bit index wraps.
    always_comb begin
        enc_in = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            enc_in[j] = elig[ID_W'(j) + last_id];
        end
    end
    assign next_id = enc_id + last_id;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_id <= '0;
        end else if (state == IDLE && enc_any) begin
            last_id <= next_id;
        end
    end
`else
    assign enc_in  = elig;
    assign next_id = enc_id;
`endif

    arb_pri_enc u_enc (
        .vec (enc_in),
        .id  (enc_id),
        .any (enc_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            hold_cnt      <= '0;
            lockout       <= '0;
        end else begin
            timeout_q <= 1'b0;
            lockout   <= lockout & bus.req;
            case (state)
                IDLE: begin
                    if (enc_any) begin
                        state         <= GRANT;
                        grant_q       <= NUM_REQ'(1) << next_id;
                        grant_id_q    <= next_id;
                        grant_valid_q <= 1'b1;
                        hold_cnt      <= '0;
                    end
                end
                GRANT: begin
                    // A release on the timeout edge wins: no pulse, no lockout.
                    if (!bus.req[grant_id_q]) begin
                        state         <= IDLE;
                        grant_q       <= '0;
                        grant_valid_q <= 1'b0;
                    end else if (timeout_hit) begin
                        state         <= IDLE;
                        grant_q       <= '0;
                        grant_valid_q <= 1'b0;
                        timeout_q     <= 1'b1;
                        lockout       <= (lockout & bus.req) | (NUM_REQ'(1) << grant_id_q);
                    end else if (MAX_HOLD != 0) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant         = grant_q;
    assign bus.grant_id      = grant_id_q;
    assign bus.grant_valid   = grant_valid_q;
    assign bus.timeout_pulse = timeout_q;
endmodule

// File: tb/tb_req_arbiter_8.sv
// Bench for req_arbiter_8: one instance with MAX_HOLD=4, one with the timeout disabled.
// The rotating-priority sequence runs only when ARB_ROUND_ROBIN_EN is defined.
module tb_req_arbiter_8;
    import arb_pkg::*;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] grant;
        logic [2:0] id;
        logic       vld;
        logic       to;
    } vec_t;

    typedef struct {
        int   dut;
        vec_t v;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    sb_t  sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    req_arbiter_8_if ifa();
    req_arbiter_8_if ifb();

    req_arbiter_8 #(.MAX_HOLD(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    req_arbiter_8 #(.MAX_HOLD(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    function automatic vec_t mk(input logic rst, input logic [7:0] req, input logic [7:0] grant,
                                input logic [2:0] id, input logic vld, input logic to);
        vec_t v;
        v.rst = rst; v.req = req; v.grant = grant; v.id = id; v.vld = vld; v.to = to;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it against the addressed instance.
    task automatic check_out();
        sb_t        e;
        logic [7:0] g;
        logic [2:0] id;
        logic       vl;
        logic       to;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty at %0t", $time);
            return;
        end
        e = sb.pop_front();
        if (e.dut == 0) begin
            g = ifa.grant; id = ifa.grant_id; vl = ifa.grant_valid; to = ifa.timeout_pulse;
        end else begin
            g = ifb.grant; id = ifb.grant_id; vl = ifb.grant_valid; to = ifb.timeout_pulse;
        end
        chk($sformatf("grant[dut%0d]", e.dut), g, e.v.grant);
        chk($sformatf("grant_valid[dut%0d]", e.dut), {7'b0, vl}, {7'b0, e.v.vld});
        chk($sformatf("timeout_pulse[dut%0d]", e.dut), {7'b0, to}, {7'b0, e.v.to});
        if (e.v.vld || !e.v.rst)
            chk($sformatf("grant_id[dut%0d]", e.dut), {5'b0, id}, {5'b0, e.v.id});
    endtask

    // Drive one cycle of stimulus, record the expected post-edge outputs, check on the falling edge.
    task automatic step(input int dut, input vec_t v);
        sb_t e;
        rst_n = v.rst;
        if (dut == 0) ifa.req = v.req;
        else          ifb.req = v.req;
        e.dut = dut;
        e.v   = v;
        sb.push_back(e);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        int seq[9];
        ifa.req = '0;
        ifb.req = '0;

        // MAX_HOLD=4 instance: reset, priority, timeout, lockout, release gap, mid-grant reset.
        tbl.push_back(mk(0, 8'h00, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(0, 8'h04, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(1, 8'h04, 8'h04, 3'd2, 1, 0));
        tbl.push_back(mk(1, 8'h00, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(1, 8'h91, 8'h80, 3'd7, 1, 0));
        tbl.push_back(mk(1, 8'h11, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(1, 8'h11, 8'h10, 3'd4, 1, 0));
        tbl.push_back(mk(1, 8'h00, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(1, 8'h02, 8'h02, 3'd1, 1, 0));
        tbl.push_back(mk(1, 8'h02, 8'h02, 3'd1, 1, 0));
        tbl.push_back(mk(1, 8'h02, 8'h02, 3'd1, 1, 0));
        tbl.push_back(mk(1, 8'h02, 8'h02, 3'd1, 1, 0));
        tbl.push_back(mk(1, 8'h02, 8'h00, 3'd0, 0, 1));
        tbl.push_back(mk(1, 8'h02, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(1, 8'h02, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(1, 8'h02, 8'h02, 3'd1, 1, 0));
        tbl.push_back(mk(1, 8'h00, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(1, 8'h02, 8'h02, 3'd1, 1, 0));
        tbl.push_back(mk(1, 8'h02, 8'h02, 3'd1, 1, 0));
        tbl.push_back(mk(1, 8'h02, 8'h02, 3'd1, 1, 0));
        tbl.push_back(mk(1, 8'h02, 8'h02, 3'd1, 1, 0));
        tbl.push_back(mk(1, 8'h00, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(1, 8'h02, 8'h02, 3'd1, 1, 0));
        tbl.push_back(mk(1, 8'h00, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(1, 8'h08, 8'h08, 3'd3, 1, 0));
        tbl.push_back(mk(1, 8'h20, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(1, 8'h20, 8'h20, 3'd5, 1, 0));
        tbl.push_back(mk(1, 8'h00, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(1, 8'h40, 8'h40, 3'd6, 1, 0));
        tbl.push_back(mk(0, 8'h40, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(1, 8'h40, 8'h40, 3'd6, 1, 0));
        tbl.push_back(mk(1, 8'h00, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(1, 8'h01, 8'h01, 3'd0, 1, 0));
        tbl.push_back(mk(1, 8'h00, 8'h00, 3'd0, 0, 0));

        foreach (tbl[i]) step(0, tbl[i]);

        // Timeout disabled: a higher request never preempts, no pulse however long the hold.
        step(1, mk(1, 8'h02, 8'h02, 3'd1, 1, 0));
        for (int k = 0; k < 55; k++) step(1, mk(1, 8'h42, 8'h02, 3'd1, 1, 0));
        step(1, mk(1, 8'h40, 8'h00, 3'd0, 0, 0));
        step(1, mk(1, 8'h40, 8'h40, 3'd6, 1, 0));
        step(1, mk(1, 8'h00, 8'h00, 3'd0, 0, 0));

`ifdef ARB_ROUND_ROBIN_EN
        // Each owner releases after one cycle; priority rotates away from it.
        step(0, mk(0, 8'h00, 8'h00, 3'd0, 0, 0));
        seq[0] = 7; seq[1] = 6; seq[2] = 5; seq[3] = 4; seq[4] = 3;
        seq[5] = 2; seq[6] = 1; seq[7] = 0; seq[8] = 7;
        for (int i = 0; i < 9; i++) begin
            logic [7:0] oh;
            oh = 8'h01 << seq[i];
            step(0, mk(1, 8'hFF, oh, 3'(seq[i]), 1, 0));
            step(0, mk(1, 8'hFF & ~oh, 8'h00, 3'd0, 0, 0));
        end
`else
        seq[0] = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
